fpu_addsub_seq: RTL

//  Parametrised multi-cycle IEEE 754 adder/subtractor with valid/ready handshakes, for the FPU datapath.

---
 rtl/fpu_addsub_seq_if.sv | 32 +++
 rtl/fpu_addsub_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential IEEE 754 adder/subtractor.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface fpu_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_nv;
    logic         flag_of;
    logic         flag_nx;
    logic         busy;

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, result, flag_nv, flag_of, flag_nx, busy
    );

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, result, flag_nv, flag_of, flag_nx, busy
    );
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE 754 add/sub with RNE rounding, subnormals and nv/of/nx flags.
// Latency: 5+L rising edges from accept for finite operands (L = left-normalise shifts), 2 for specials.
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
module fpu_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    fpu_addsub_seq_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 3;      // aligned Y: hidden+fraction, G, R
    localparam int AW = MAN_W + 5;      // accumulator: carry, hidden+fraction, G, R, S
    localparam int WW = 2 * MAN_W + 4;  // alignment shifter: Y mantissa plus room for every dropped bit
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(MAN_W + 3);
    localparam logic [EXP_W:0]   EXP_INF  = {1'b0, EXP_ONES};
    localparam logic [EXP_W:0]   E_ONE    = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    state_t         state;
    logic [W-1:0]   opa, opb;
    logic           sx, sy;
    logic [EXP_W:0] ex;
    logic [MAN_W:0] xm_r;
    logic [FW-1:0]  yal;
    logic           ys;
    logic [AW-1:0]  acc;
    logic           in_ready_r, out_valid_r, busy_r, nv_r, of_r, nx_r;
    logic [W-1:0]   result_r;

    logic [EXP_W-1:0] ea, eb, xe, ye, xeff, yeff, diff, dsh;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   xm, ym;
    logic [WW-1:0]    ywide;
    logic [W-1:0]     xop, yop;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, a_big;

    // Classify the captured operands, order them by magnitude and align Y under X
    always_comb begin
        ea     = opa[W-2 -: EXP_W];
        eb     = opb[W-2 -: EXP_W];
        fa     = opa[MAN_W-1:0];
        fb     = opb[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_zero = (ea == '0) && (fa == '0);
        b_zero = (eb == '0) && (fb == '0);
        a_big  = opa[W-2:0] >= opb[W-2:0];
        xop    = a_big ? opa : opb;
        yop    = a_big ? opb : opa;
        xe     = xop[W-2 -: EXP_W];
        ye     = yop[W-2 -: EXP_W];
        // a zero exponent field is a subnormal: exponent 1 with no hidden bit
        xeff   = (xe == '0) ? EXP_W'(1) : xe;
        yeff   = (ye == '0) ? EXP_W'(1) : ye;
        xm     = {xe != '0, xop[MAN_W-1:0]};
        ym     = {ye != '0, yop[MAN_W-1:0]};
        diff   = xeff - yeff;
        dsh    = (diff > SH_MAX) ? SH_MAX : diff;
        ywide  = {ym, {(MAN_W+3){1'b0}}} >> dsh;
    end

    logic [AW-1:0]    xv, yv, sum;
    logic [MAN_W:0]   rmant;
    logic [MAN_W+1:0] mr;
    logic [EXP_W:0]   er;
    logic             rg, rr, rs, rinc, rhid;

    // Magnitude add/subtract of the aligned operands and the round-to-nearest-even increment
    always_comb begin
        xv    = {1'b0, xm_r, 3'b000};
        yv    = {1'b0, yal, ys};
        sum   = (sx ^ sy) ? (xv - yv) : (xv + yv);
        rmant = acc[AW-2:3];
        rg    = acc[2];
        rr    = acc[1];
        rs    = acc[0];
        rinc  = rg & (rr | rs | rmant[0]);
        mr    = {1'b0, rmant} + {{(MAN_W+1){1'b0}}, rinc};
        er    = ex + {{EXP_W{1'b0}}, mr[MAN_W+1]};
        rhid  = mr[MAN_W+1] | mr[MAN_W];
    end

    // Control FSM and datapath registers; all outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= '0;
            nv_r        <= 1'b0;
            of_r        <= 1'b0;
            nx_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        opa        <= bus.a;
                        opb        <= {bus.b[W-1] ^ bus.op_sub, bus.b[W-2:0]};
                        result_r   <= '0;
                        nv_r       <= 1'b0;
                        of_r       <= 1'b0;
                        nx_r       <= 1'b0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (a_nan || b_nan) begin
                        result_r    <= QNAN;
                        nv_r        <= a_snan | b_snan;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else if (a_inf && b_inf && (opa[W-1] != opb[W-1])) begin
                        result_r    <= QNAN;
                        nv_r        <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else if (a_inf || b_inf) begin
                        result_r    <= a_inf ? opa : opb;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else if (a_zero != b_zero) begin
                        result_r    <= a_zero ? opb : opa;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        sx    <= xop[W-1];
                        sy    <= yop[W-1];
                        ex    <= {1'b0, xeff};
                        xm_r  <= xm;
                        yal   <= ywide[WW-1 -: FW];
                        ys    <= |ywide[WW-FW-1:0];
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (sum == '0) begin
                        // exact cancellation is +0 unless both inputs were -0
                        result_r    <= {sx & sy, {(W-1){1'b0}}};
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        acc   <= sum;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (acc[AW-1]) begin
                        acc   <= {1'b0, acc[AW-1:2], acc[1] | acc[0]};
                        ex    <= ex + E_ONE;
                        state <= S_ROUND;
                    end else if (!acc[AW-2] && (ex > E_ONE)) begin
                        acc <= acc << 1;
                        ex  <= ex - E_ONE;
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    nx_r <= rg | rr | rs;
                    if (er >= EXP_INF) begin
                        result_r <= {sx, EXP_ONES, {MAN_W{1'b0}}};
                        of_r     <= 1'b1;
                        nx_r     <= 1'b1;
                    end else begin
                        // a subnormal whose rounding sets the hidden bit becomes the smallest normal
                        result_r <= {sx, (rhid ? er[EXP_W-1:0] : {EXP_W{1'b0}}), mr[MAN_W-1:0]};
                    end
                    out_valid_r <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.result    = result_r;
    assign bus.flag_nv   = nv_r;
    assign bus.flag_of   = of_r;
    assign bus.flag_nx   = nx_r;
endmodule
